// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding load/store with a fixed access latency.
// Define DMEM_ERR_CHECK_EN to flag misaligned and out-of-range addresses as errors.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic              accept, commit;

  logic              lat_we;
  logic [31:0]       lat_addr, lat_wdata;
  logic [3:0]        lat_be;

  logic              op_we, op_err;
  logic [31:0]       op_addr, op_wdata;
  logic [3:0]        op_be;
  logic [ADDR_W-1:0] op_idx;

  logic [31:0]       mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // commit marks the edge that enters RESP; reset on that edge cancels the access
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req_ready  = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (req_valid && !reset) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_next = RESP;
          cnt_next   = 4'd0;
          commit     = !reset;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  // With single-cycle latency the commit edge is the accept edge, so use the live request
  assign op_we    = (state == IDLE) ? req_we    : lat_we;
  assign op_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign op_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign op_be    = (state == IDLE) ? req_be    : lat_be;
  assign op_idx   = op_addr[ADDR_W+1:2];

`ifdef DMEM_ERR_CHECK_EN
  assign op_err = (op_addr[1:0] != 2'b00) || ((op_addr >> (ADDR_W + 2)) != 32'd0);
`else
  logic unused_addr_bits;
  assign op_err           = 1'b0;
  assign unused_addr_bits = ^{op_addr[31:ADDR_W+2], op_addr[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= op_err;
      rsp_rdata <= (op_we || op_err) ? 32'd0 : mem[op_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (commit && op_we && !op_err) begin
      for (int i = 0; i < 4; i++) begin
        if (op_be[i]) mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances with LATENCY 2, 1 and 7.
// Expected responses come from a bench-side word model and are queued at acceptance.
module tb_dmem_responder;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  logic [31:0] model [3][1024];
  exp_t        sb[$];
  int          last_accept [3];
  int          cycle = 0;
  int          tests = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .DEPTH  (1024),
      .ADDR_W (10),
      .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 7))
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we   (req_we[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .req_be   (req_be[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  function automatic int latOf(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 7);
  endfunction

  function automatic bit addrErr(input logic [31:0] a);
`ifdef DMEM_ERR_CHECK_EN
    return (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t expectOp(input int k, input bit we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    int   idx;
    idx     = int'(addr[11:2]);
    e.err   = addrErr(addr);
    e.rdata = 32'h0;
    if (!e.err) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) model[k][idx][8*i +: 8] = wdata[8*i +: 8];
        end
      end else begin
        e.rdata = model[k][idx];
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge before the response handshake edge
  // when hold==0, so an immediate follow-up call exercises minimum request spacing.
  task automatic applyStimulus(input int k, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input int hold, input bit chk_gap);
    exp_t e;
    int   guard;
    int   n;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_be[k]    = be;
    guard = 0;
    while (req_ready[k] !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (req_ready[k] !== 1'b1) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      req_valid[k] = 1'b0;
      return;
    end
    if (chk_gap) checkOutput("req_spacing", cycle - last_accept[k], latOf(k) + 1);
    last_accept[k] = cycle;
    sb.push_back(expectOp(k, we, addr, wdata, be));
    @(negedge clk);
    req_valid[k] = 1'b0;
    n = 1;
    while (rsp_valid[k] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("latency", n, latOf(k));
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (rsp_valid[k] !== 1'b1) return;
    rsp_ready[k] = (hold == 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("bp_valid", rsp_valid[k], 32'd1);
      checkOutput("bp_req_ready", req_ready[k], 32'd0);
      checkOutput("bp_rdata", rsp_rdata[k], e.rdata);
      checkOutput("bp_err", rsp_err[k], e.err);
    end
    rsp_ready[k] = 1'b1;
    checkOutput("rdata", rsp_rdata[k], e.rdata);
    checkOutput("err", rsp_err[k], e.err);
    if (hold > 0) begin
      @(negedge clk);
      checkOutput("idle_after_bp", req_ready[k], 32'd1);
      checkOutput("valid_dropped", rsp_valid[k], 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = 32'h0;
      req_wdata[k] = 32'h0;
      req_be[k]    = 4'h0;
      rsp_ready[k] = 1'b1;
      last_accept[k] = 0;
    end

    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_req_ready", req_ready[0], 32'd0);
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput("reset_rsp_valid", rsp_valid[k], 32'd0);
      checkOutput("reset_rsp_rdata", rsp_rdata[k], 32'd0);
      checkOutput("reset_rsp_err", rsp_err[k], 32'd0);
      checkOutput("post_reset_ready", req_ready[k], 32'd1);
    end

    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b1);
    applyStimulus(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b1);
    applyStimulus(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 1'b1);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b1);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'hF, 5, 1'b1);
    applyStimulus(0, 1'b1, 32'h10, 32'h55555555, 4'h0, 0, 1'b0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b1);
    applyStimulus(0, 1'b1, 32'h40, 32'hCAFE0000, 4'hF, 0, 1'b1);
    applyStimulus(0, 1'b0, 32'h40, 32'h0, 4'hF, 0, 1'b1);

    // store aborted by reset while waiting: no response, no array change
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h40;
    req_wdata[0] = 32'h0000FFFF;
    req_be[0]    = 4'hF;
    for (int g = 0; g < 50 && req_ready[0] !== 1'b1; g++) @(negedge clk);
    checkOutput("rstwait_accepted", req_ready[0], 32'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstwait_no_valid", rsp_valid[0], 32'd0);
    checkOutput("rstwait_req_ready", req_ready[0], 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rstwait_no_valid2", rsp_valid[0], 32'd0);
    checkOutput("rstwait_rdata", rsp_rdata[0], 32'd0);
    applyStimulus(0, 1'b0, 32'h40, 32'h0, 4'hF, 0, 1'b0);

    applyStimulus(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, 1'b1);
    applyStimulus(0, 1'b0, 32'h1000, 32'h0, 4'hF, 0, 1'b1);
    applyStimulus(0, 1'b1, 32'h1002, 32'h12345678, 4'hF, 0, 1'b1);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b1);
    applyStimulus(0, 1'b0, 32'h11, 32'h0, 4'hF, 0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      a = 32'($urandom_range(64, 127)) << 2;
      d = $urandom;
      applyStimulus(0, 1'b1, a, d, 4'hF, 0, 1'b0);
      d = $urandom;
      applyStimulus(0, 1'b1, a, d, 4'($urandom_range(0, 15)), 0, 1'b1);
      applyStimulus(0, 1'b0, a, 32'h0, 4'hF, 0, 1'b1);
    end

    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      applyStimulus(k, 1'b1, 32'h10, 32'hA5A5F00F, 4'hF, 0, 1'b0);
      applyStimulus(k, 1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b1);
      applyStimulus(k, 1'b1, 32'h14, 32'h0BADCAFE, 4'b1010, 0, 1'b1);
      applyStimulus(k, 1'b1, 32'h14, 32'h76543210, 4'b0101, 0, 1'b1);
      applyStimulus(k, 1'b0, 32'h14, 32'h0, 4'hF, 0, 1'b1);
      applyStimulus(k, 1'b0, 32'h10, 32'h0, 4'hF, 3, 1'b1);
    end

    @(negedge clk);
    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the core's load/store request interface.
- Accepts one word-oriented request at a time over a valid/ready request channel.
- Models a configurable access latency, performs the read or byte-masked write on an internal word array, and returns the result over a valid/ready response channel.
- Sits between the core's MEM-stage memory port and the backing store; used as the slave model for stall/latency testing of the pipeline.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two).
- ADDR_W, 10, log2(DEPTH); word-index width.
- LATENCY, 2, cycles from request acceptance to rsp_valid (1..15).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables; bit i enables byte i (bits 8i+7:8i).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  access error (see Optional Feature).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, req_ready=0 in the reset cycle then 1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter 0. Array contents are not cleared.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/wdata/be. If LATENCY==1 go to RESP, else go to WAIT with cnt=LATENCY-1.
  - WAIT: req_ready=0. cnt decrements each cycle; at cnt==1 go to RESP.
  - RESP: req_ready=0, rsp_valid=1. On rsp_valid&&rsp_ready go to IDLE.
- Latency: rsp_valid rises exactly LATENCY cycles after the accepting edge.
- Commit point: the array access happens on the edge that enters RESP.
  - Load: rsp_rdata = array[addr[ADDR_W+1:2]], full word regardless of be.
  - Store: only enabled bytes are written; rsp_rdata=0.
- Stability: rsp_rdata and rsp_err stay constant while rsp_valid=1 && !rsp_ready.
- Throughput: single outstanding request. A new request is accepted no earlier than the cycle after the response handshake, so the minimum request-to-request spacing is LATENCY+1 cycles.
- req_valid while req_ready=0 is ignored; the core must hold it.
- Bytes: be=4'b0000 on a store completes normally with no array change.
- Reset mid-operation:
  - In WAIT: the latched store is discarded with no array change, and no response is issued.
  - In RESP: the response is dropped; a store has already committed.
- Read-after-write: a load accepted after a store's response returns the stored data.

Optional Feature:
- Macro: DMEM_ERR_CHECK_EN.
- Defined: an access is an error when req_addr[1:0]!=0 (misaligned) or req_addr[31:ADDR_W+2]!=0 (out of range). An errored access:
  - performs no array write;
  - returns rsp_err=1 and rsp_rdata=0;
  - keeps the same latency and handshake.
- Undefined:
  - rsp_err is tied to 0.
  - req_addr[1:0] and the upper bits are ignored; the word index is addr[ADDR_W+1:2], wrapping modulo DEPTH.

Test Plan:
- Basic store then load, LATENCY=2, rsp_ready=1: store addr=0x10, wdata=0xDEADBEEF, be=4'hF; rsp_valid 2 cycles after acceptance. Then load addr=0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte mask: preload 0x11223344 at 0x20; store wdata=0xAABBCCDD, be=4'b0101 -> later load returns 0x11BB33DD.
- Backpressure: hold rsp_ready=0 for 5 cycles on a load -> rsp_valid, rsp_rdata and rsp_err stable and req_ready=0 throughout; IDLE the cycle after rsp_ready=1.
- Latency sweep LATENCY=1 and LATENCY=7 -> rsp_valid exactly 1 and 7 cycles after acceptance; back-to-back requests spaced LATENCY+1 cycles.
- Reset in WAIT: issue store 0x0000FFFF to 0x40 and assert reset after 1 cycle -> no rsp_valid; later load of 0x40 returns the prior contents.
- Errors with DMEM_ERR_CHECK_EN, DEPTH=1024:
  - store to 0x1002 -> rsp_err=1 and no write;
  - load from 0x1000 -> rsp_err=1, rsp_rdata=0.
  - Without the macro, a load from 0x1000 returns the word at 0x0000 with rsp_err=0.
